// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide sequencer: op encodings, FSM states and
// the iteration-counter width helper.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;
  localparam int unsigned CNT_W        = $clog2(MULDIV_WIDTH);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t FIX  = 2'd2;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or restoring divide.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
`ifdef MULDIV_DIV_EN
  input  logic               is_div,
`endif
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   shreg_in,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0]   shreg_out
);

  logic [WIDTH:0] add_sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
`endif

  always_comb begin
    // Multiply: add into the upper half, then shift right keeping the carry.
    add_sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (shreg_in[0] ? {1'b0, mcand} : '0);
    acc_out   = {add_sum, acc_in[WIDTH-1:1]};
    shreg_out = shreg_in >> 1;
`ifdef MULDIV_DIV_EN
    // Divide: dividend bits stream in from shreg MSB; the borrow bit decides restore.
    rem_sh = {acc_in[2*WIDTH-1:WIDTH], shreg_in[WIDTH-1]};
    trial  = rem_sh - {1'b0, mcand};
    if (is_div) begin
      if (!trial[WIDTH]) begin
        acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
      shreg_out = shreg_in << 1;
    end
`endif
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning HI/LO. Divide support is built only when
// MULDIV_DIV_EN is defined; otherwise divide starts pulse div_unsupported.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_unsupported
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_t               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, step_acc, prod;
  logic [WIDTH-1:0]     shreg_q, shreg_d, step_shreg, mcand_q, mcand_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d, res_hi, res_lo;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 neg_q, neg_d, done_q, done_d;
  logic                 op_signed, op_div, a_neg, b_neg, start_ok, launch;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign a_neg     = op_signed & srca[WIDTH-1];
  assign b_neg     = op_signed & srcb[WIDTH-1];
  assign a_mag     = a_neg ? -srca : srca;
  assign b_mag     = b_neg ? -srcb : srcb;
  assign start_ok  = (state_q == IDLE) && start && !cancel;

`ifdef MULDIV_DIV_EN
  logic div_q, div_d, rem_neg_q, rem_neg_d, bzero_q, bzero_d;
  assign launch          = start_ok;
  assign div_unsupported = 1'b0;
`else
  logic unsup_q;
  assign launch          = start_ok && !op_div;
  assign div_unsupported = unsup_q;
`endif

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
`ifdef MULDIV_DIV_EN
    .is_div    (div_q),
`endif
    .acc_in    (acc_q),
    .shreg_in  (shreg_q),
    .mcand     (mcand_q),
    .acc_out   (step_acc),
    .shreg_out (step_shreg)
  );

  always_comb begin
    prod   = neg_q ? -acc_q : acc_q;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    // Divide by zero: the remainder already equals srca, only LO needs forcing.
    if (div_q) begin
      res_hi = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      res_lo = bzero_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    shreg_d = shreg_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
    div_d     = div_q;
    rem_neg_d = rem_neg_q;
    bzero_d   = bzero_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (hi_wr) hi_d = wdata;
        if (lo_wr) lo_d = wdata;
        if (launch) begin
          state_d = RUN;
          cnt_d   = CntW'(WIDTH - 1);
          acc_d   = '0;
          neg_d   = a_neg ^ b_neg;
          shreg_d = b_mag;
          mcand_d = a_mag;
`ifdef MULDIV_DIV_EN
          div_d     = op_div;
          rem_neg_d = a_neg;
          bzero_d   = (srcb == '0);
          if (op_div) begin
            shreg_d = a_mag;
            mcand_d = b_mag;
          end
`endif
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          acc_d   = step_acc;
          shreg_d = step_shreg;
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - CntW'(1);
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      shreg_q <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      bzero_q   <= 1'b0;
`else
      unsup_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      shreg_q <= shreg_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MULDIV_DIV_EN
      div_q     <= div_d;
      rem_neg_q <= rem_neg_d;
      bzero_q   <= bzero_d;
`else
      unsup_q <= start_ok && op_div;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
